// File: rtl/tdm_demux_1_8_if.sv
`default_nettype none
// tdm_demux_1_8_if: serial-in / parallel-out bundle for the 1:8 TDM demux. Rev 1.0
interface tdm_demux_1_8_if;
  logic       din;
  logic       din_valid;
  logic       sync;
  logic [7:0] D;
  logic [2:0] S;
  logic       frame_valid;
  logic       parity_err;

  modport master (
    output din, din_valid, sync,
    input  D, S, frame_valid, parity_err
  );

  modport slave (
    input  din, din_valid, sync,
    output D, S, frame_valid, parity_err
  );
endinterface
`default_nettype wire

// File: rtl/tdm_demux_1_8.sv
`default_nettype none
// tdm_demux_1_8: 1-to-8 TDM serial demux with one-cycle frame strobe; optional even-parity slot
// when TDM_DEMUX_PARITY_EN is defined. Rev 1.0
module tdm_demux_1_8 #(
  parameter int N_CH        = 8,
  parameter bit SYNC_CLEARS = 1'b1
) (
  input logic            clk,
  input logic            rst,
  tdm_demux_1_8_if.slave bus
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int            SW   = $clog2(N_CH);
  localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_t;

  state_t          state;
  logic [N_CH-1:0] shadow;
  logic [N_CH-1:0] word;
  logic [SW-1:0]   slot;
  logic            fv;
  logic            perr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= COLLECT;
      shadow <= '0;
      word   <= '0;
      slot   <= '0;
      fv     <= 1'b0;
      perr   <= 1'b0;
    end else begin
      fv   <= 1'b0;
      perr <= 1'b0;
      if (bus.sync) begin
        // Resync discards any partial or parity-pending frame.
        state <= COLLECT;
        if (bus.din_valid) begin
          shadow <= N_CH'(bus.din);
          slot   <= SW'(1);
        end else begin
          slot <= '0;
          if (SYNC_CLEARS) shadow <= '0;
        end
      end else if (bus.din_valid) begin
        if (state == PARITY) begin
          word   <= shadow;
          fv     <= 1'b1;
          perr   <= ^{shadow, bus.din};
          shadow <= '0;
          state  <= COLLECT;
        end else if (slot == LAST) begin
          slot <= '0;
          if (PARITY_EN) begin
            shadow[LAST] <= bus.din;
            state        <= PARITY;
          end else begin
            word   <= {bus.din, shadow[N_CH-2:0]};
            fv     <= 1'b1;
            shadow <= '0;
          end
        end else begin
          shadow[slot] <= bus.din;
          slot         <= slot + SW'(1);
        end
      end
    end
  end

  assign bus.D           = word;
  assign bus.S           = slot;
  assign bus.frame_valid = fv;
  assign bus.parity_err  = PARITY_EN ? perr : 1'b0;

endmodule
`default_nettype wire
